// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, frame constants and the Tx FSM states.
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;
  localparam logic LEN_7    = 1'b0;
  localparam logic LEN_8    = 1'b1;

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_parity_gen.sv
// Combinational masked XOR-reduce parity generator, shared by the Tx and Rx paths.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_length,
  input  logic [1:0]        i_parity_type,
  output logic              o_parity
);
  logic [DATA_W-1:0] w_mask;
  logic              w_xor;

  // Short frames drop the MSB from the parity calculation.
  assign w_mask = (i_data_length == LEN_8) ? {DATA_W{1'b1}} : {1'b0, {(DATA_W-1){1'b1}}};
  assign w_xor  = ^(i_data & w_mask);

  always_comb begin
    o_parity = 1'b0;
    case (i_parity_type)
      PAR_ODD:  o_parity = ~w_xor;
      PAR_EVEN: o_parity = w_xor;
      default:  o_parity = 1'b0;
    endcase
  end
endmodule

// File: rtl/uart_tx_frame_piso.sv
// UART transmit framer: latches a byte and config on send, then shifts start/data/parity/stop
// out LSB-first, advancing one bit per baud_tick.
module uart_tx_frame_piso
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic              send,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        parity_type,
  input  logic              stop_bits,
  input  logic              data_length,
  output logic              data_tx,
  output logic              active_flag,
  output logic              done_flag
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_t         r_state, w_state;
  logic              r_tx, w_tx;
  logic              r_active, w_active;
  logic              r_done, w_done;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic [CNT_W-1:0]  r_bitcnt, w_bitcnt;
  logic              r_stopcnt, w_stopcnt;
  logic [1:0]        r_par_type, w_par_type;
  logic              r_stop, w_stop;
  logic              r_len, w_len;
  logic              r_parity, w_parity;

  logic [DATA_W-1:0] w_din_masked;
  logic              w_par_bit;
  logic              w_par_en;
  logic [CNT_W-1:0]  w_nbits;

  assign w_din_masked = (data_length == LEN_8) ? data_in : {1'b0, data_in[DATA_W-2:0]};
  assign w_par_en     = (r_par_type == PAR_ODD) || (r_par_type == PAR_EVEN);
  assign w_nbits      = (r_len == LEN_8) ? CNT_W'(DATA_W) : CNT_W'(DATA_W - 1);

  uart_parity_gen #(.DATA_W(DATA_W)) u_par (
    .i_data        (data_in),
    .i_data_length (data_length),
    .i_parity_type (parity_type),
    .o_parity      (w_par_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_stopcnt  <= 1'b0;
      r_par_type <= PAR_NONE;
      r_stop     <= STOP_ONE;
      r_len      <= LEN_7;
      r_parity   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tx       <= w_tx;
      r_active   <= w_active;
      r_done     <= w_done;
      r_shift    <= w_shift;
      r_bitcnt   <= w_bitcnt;
      r_stopcnt  <= w_stopcnt;
      r_par_type <= w_par_type;
      r_stop     <= w_stop;
      r_len      <= w_len;
      r_parity   <= w_parity;
    end
  end

  // data_tx is the registered image of the bit chosen at each tick, so every transition
  // below also selects the line level for the following bit period.
  always_comb begin
    w_state    = r_state;
    w_tx       = r_tx;
    w_active   = r_active;
    w_done     = 1'b0;
    w_shift    = r_shift;
    w_bitcnt   = r_bitcnt;
    w_stopcnt  = r_stopcnt;
    w_par_type = r_par_type;
    w_stop     = r_stop;
    w_len      = r_len;
    w_parity   = r_parity;
    case (r_state)
      IDLE: begin
        w_tx = 1'b1;
        if (send) begin
          w_state    = WAIT;
          w_active   = 1'b1;
          w_shift    = w_din_masked;
          w_par_type = parity_type;
          w_stop     = stop_bits;
          w_len      = data_length;
          w_parity   = w_par_bit;
          w_bitcnt   = '0;
          w_stopcnt  = 1'b0;
        end
      end
      WAIT: if (baud_tick) begin
        w_state = START;
        w_tx    = 1'b0;
      end
      START: if (baud_tick) begin
        w_state  = DATA;
        w_tx     = r_shift[0];
        w_shift  = r_shift >> 1;
        w_bitcnt = CNT_W'(1);
      end
      DATA: if (baud_tick) begin
        if (r_bitcnt == w_nbits) begin
          w_stopcnt = 1'b0;
          if (w_par_en) begin
            w_state = PARITY;
            w_tx    = r_parity;
          end else begin
            w_state = STOP;
            w_tx    = 1'b1;
          end
        end else begin
          w_tx     = r_shift[0];
          w_shift  = r_shift >> 1;
          w_bitcnt = r_bitcnt + 1'b1;
        end
      end
      PARITY: if (baud_tick) begin
        w_state   = STOP;
        w_tx      = 1'b1;
        w_stopcnt = 1'b0;
      end
      STOP: if (baud_tick) begin
        if (r_stopcnt == r_stop) begin
          w_state  = IDLE;
          w_done   = 1'b1;
          w_active = 1'b0;
          w_tx     = 1'b1;
        end else begin
          w_stopcnt = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign data_tx     = r_tx;
  assign active_flag = r_active;
  assign done_flag   = r_done;
endmodule
